// File: rtl/riscv_run_ctrl.sv
// Run controller for the RISC-V IP: sequences core reset, a bounded run window and
// completion, and turns instruction-write ticks into range-checked IMEM write strobes.
module riscv_run_ctrl #(
  parameter int IMEM_AW = 10,
  parameter int DATA_W  = 32
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESETN,
  input  logic                 i_run,
  input  logic [31:0]          i_num_cycle,
  input  logic                 i_mem_reset_n,
  input  logic                 i_instr_write,
  input  logic [31:0]          i_instr_addr,
  input  logic [DATA_W-1:0]    i_instr_data,
  input  logic                 i_core_halt,
  output logic                 o_idle,
  output logic                 o_running,
  output logic                 o_done,
  output logic                 o_core_en,
  output logic                 o_core_reset_n,
  output logic                 o_imem_we,
  output logic [IMEM_AW-1:0]   o_imem_addr,
  output logic [DATA_W-1:0]    o_imem_wdata,
  output logic [31:0]          o_cycle_count,
  output logic [IMEM_AW:0]     o_instr_count,
  output logic                 o_load_err
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CORE_RST = 2'd1,
    ST_RUN      = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam logic [IMEM_AW:0] IC_MAX = {1'b1, {IMEM_AW{1'b0}}};

  state_t              r_state;
  state_t              w_next;
  logic [31:0]         r_n;
  logic [31:0]         r_cnt;
  logic                r_imem_we;
  logic [IMEM_AW-1:0]  r_imem_addr;
  logic [DATA_W-1:0]   r_imem_wdata;
  logic [IMEM_AW:0]    r_instr_count;
  logic                r_load_err;

  logic w_run_acc;
  logic w_addr_ok;
  logic w_wr_acc;
  logic w_wr_rej;
  logic w_run_last;
  logic w_idle;
  logic w_running;
  logic w_done;
  logic w_core_en;
  logic w_core_rst;

  assign w_run_acc  = (r_state == ST_IDLE) && i_run && i_mem_reset_n;
  assign w_addr_ok  = (i_instr_addr[1:0] == 2'b00) && (i_instr_addr[31:IMEM_AW+2] == '0);
  assign w_wr_acc   = i_instr_write && i_mem_reset_n && (r_state == ST_IDLE) && w_addr_ok;
  // Writes while the memory is held in reset are dropped silently, not flagged.
  assign w_wr_rej   = i_instr_write && i_mem_reset_n && !w_wr_acc;
  assign w_run_last = (r_cnt == (r_n - 32'd1)) || i_core_halt;

  // State register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_run_acc) begin
          w_next = (i_num_cycle == 32'd0) ? ST_DONE : ST_CORE_RST;
        end
      end
      ST_CORE_RST: begin
        w_next = i_mem_reset_n ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        if (!i_mem_reset_n) begin
          w_next = ST_IDLE;
        end else if (w_run_last) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Decoded outputs
  always_comb begin
    w_idle     = 1'b0;
    w_running  = 1'b0;
    w_done     = 1'b0;
    w_core_en  = 1'b0;
    w_core_rst = 1'b0;
    case (r_state)
      ST_IDLE:     w_idle = 1'b1;
      ST_CORE_RST: begin
        w_running  = 1'b1;
        w_core_rst = 1'b1;
      end
      ST_RUN: begin
        w_running = 1'b1;
        w_core_en = 1'b1;
      end
      ST_DONE:     w_done = 1'b1;
      default:     w_idle = 1'b0;
    endcase
  end

  // The run budget is latched at acceptance; the cycle count stops on abort so a
  // partial run reports only the cycles the core actually executed out of reset.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_n   <= 32'd0;
      r_cnt <= 32'd0;
    end else if (w_run_acc) begin
      r_n   <= i_num_cycle;
      r_cnt <= 32'd0;
    end else if ((r_state == ST_RUN) && i_mem_reset_n) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  // Loader: strobe is registered so it lands one cycle after the write tick
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
    end else begin
      r_imem_we <= w_wr_acc;
      if (w_wr_acc) begin
        r_imem_addr  <= i_instr_addr[IMEM_AW+1:2];
        r_imem_wdata <= i_instr_data;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_instr_count <= '0;
    end else if (!i_mem_reset_n) begin
      r_instr_count <= '0;
    end else if (w_wr_acc && (r_instr_count != IC_MAX)) begin
      r_instr_count <= r_instr_count + 1'b1;
    end
  end

  // A rejection in the same cycle as an accepted run keeps the error visible.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_load_err <= 1'b0;
    end else if (w_wr_rej) begin
      r_load_err <= 1'b1;
    end else if (w_run_acc) begin
      r_load_err <= 1'b0;
    end
  end

  assign o_idle         = w_idle;
  assign o_running      = w_running;
  assign o_done         = w_done;
  assign o_core_en      = w_core_en;
  assign o_core_reset_n = S_AXI_ARESETN & i_mem_reset_n & ~w_core_rst;
  assign o_imem_we      = r_imem_we;
  assign o_imem_addr    = r_imem_addr;
  assign o_imem_wdata   = r_imem_wdata;
  assign o_cycle_count  = r_cnt;
  assign o_instr_count  = r_instr_count;
  assign o_load_err     = r_load_err;

endmodule

// File: doc/riscv_run_ctrl.md
Name: riscv_run_ctrl

Overview:
- Sits directly downstream of the AXI4-Lite register slave for the RISC-V IP.
- Consumes its run tick, cycle budget, memory-reset level, instruction-write tick and the address/data registers (slv_reg5/slv_reg6).
- Sequences the core through reset, a bounded run window and completion, and produces the idle/running/done status the slave reads back.
- Also converts instruction-write ticks into single-cycle instruction-memory write strobes with range checking.

Parameters:
- IMEM_AW, 10, instruction memory word-address width; memory depth is 2^IMEM_AW words.
- DATA_W, 32, instruction/data width.

Ports:
- S_AXI_ACLK  in  1  single clock.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- i_run  in  1  1-cycle start tick (w_o_run).
- i_num_cycle  in  32  run budget in core-enabled cycles (w_o_num_cycle).
- i_mem_reset_n  in  1  level; 0 = hold core/loader in reset (w_mem_reset_n).
- i_instr_write  in  1  1-cycle instruction-write tick (w_instruction_write).
- i_instr_addr  in  32  byte address of instruction (w_slv_reg5).
- i_instr_data  in  DATA_W  instruction word (w_slv_reg6).
- i_core_halt  in  1  core requests stop (ebreak/ecall), sampled only in RUN.
- o_idle  out  1  to slave status bit 0.
- o_running  out  1  to slave status bit 1.
- o_done  out  1  1-cycle done tick to slave status bit 2.
- o_core_en  out  1  core clock-enable.
- o_core_reset_n  out  1  core reset, active-low.
- o_imem_we  out  1  instruction memory write strobe.
- o_imem_addr  out  IMEM_AW  word address.
- o_imem_wdata  out  DATA_W  write data.
- o_cycle_count  out  32  core-enabled cycles elapsed in current/last run.
- o_instr_count  out  IMEM_AW+1  successful instruction writes since memory reset.
- o_load_err  out  1  sticky load error.

Behaviour:
- Asynchronous reset values:
  - state=IDLE.
  - o_idle=1.
  - All other outputs 0, including o_core_reset_n=0 (core held in reset), counters and o_load_err.
- FSM states and transitions:
  - IDLE: on i_run && i_mem_reset_n, latch N=i_num_cycle, clear o_cycle_count, and clear o_load_err, then go to CORE_RST. If N==0, go straight to DONE instead.
  - CORE_RST: exactly 1 cycle, o_core_reset_n=0, then go to RUN.
  - RUN: o_core_en=1 and cnt increments each cycle. Go to DONE when cnt==N-1 or i_core_halt=1; both in the same cycle produce a single transition. The halt cycle counts as an enabled cycle.
  - DONE: exactly 1 cycle, o_done=1, then go to IDLE.
- Decoded outputs:
  - o_idle=(IDLE).
  - o_running=(CORE_RST|RUN).
  - o_core_en=(RUN).
- o_core_reset_n:
  - Equals i_mem_reset_n in IDLE/RUN/DONE.
  - Forced 0 in CORE_RST.
- Run latency:
  - Tick at cycle T puts the FSM in CORE_RST at T+1.
  - RUN spans T+2..T+N+1.
  - o_done is high at T+N+2.
  - IDLE again at T+N+3.
  - o_cycle_count ends at N, or at the halt count, and holds until the next accepted run.
- i_run outside IDLE: ignored; no re-latch of N.
- i_num_cycle changes after latch: no effect on the current run.
- i_mem_reset_n=0 in CORE_RST/RUN: abort to IDLE next cycle with no o_done; o_cycle_count keeps its partial value.
- i_mem_reset_n=0 in any state: o_instr_count cleared; run ticks and write ticks ignored; no error is flagged.
- Loader acceptance:
  - A write tick is accepted only when state==IDLE, i_mem_reset_n=1, i_instr_addr[1:0]==0, and i_instr_addr[31:IMEM_AW+2]==0.
  - On acceptance: o_imem_we=1 on the following cycle only, o_imem_addr=i_instr_addr[IMEM_AW+1:2], o_imem_wdata=i_instr_data (both registered), and o_instr_count increments, saturating at 2^IMEM_AW.
- Loader rejection:
  - Applies to misaligned addresses, out-of-range addresses, or a tick arriving in a non-IDLE state.
  - No strobe is issued and o_load_err is set sticky.
  - o_load_err is cleared only by an accepted run or by reset.
- Write tick and run tick in the same cycle in IDLE: both accepted; the strobe issues during CORE_RST.
- Error set and clear in the same cycle: a rejected write coinciding with an accepted run leaves o_load_err=1 (set wins).
- Counter widths: cnt and o_cycle_count are 32-bit and cannot exceed N, so they never wrap.

Test Plan:
- Reset, then write 0x00000013 to addr 0x8 -> o_imem_we=1 one cycle later with addr=2 and wdata=0x00000013; o_instr_count=1; o_load_err=0.
- i_num_cycle=5, i_run tick at T -> o_core_reset_n=0 at T+1; o_core_en=1 for exactly 5 cycles; o_done=1 only at T+7; o_idle=1 at T+8; o_cycle_count=5.
- N=100 with i_core_halt pulsed on the 3rd RUN cycle -> DONE next cycle, o_cycle_count=3, single o_done; the same with halt on cycle 100 -> one o_done.
- Writes to addr 0x6 (misaligned) and 0x1000 (out of range for IMEM_AW=10), plus a write during RUN -> no o_imem_we, o_load_err=1; the next run tick clears it.
- N=0 run tick -> o_done at T+1; no CORE_RST or RUN; o_core_en never 1; o_cycle_count=0.
- i_mem_reset_n dropped mid-RUN at count 4 (N=10) -> IDLE next cycle with no o_done, o_cycle_count=4, o_instr_count=0; asserting S_AXI_ARESETN mid-run -> all outputs immediately at reset values.
